// File: rtl/mvau_inp_buf_ctrl.sv
// Sequencer for the MVAU input activation buffer: writes each input vector once during
// neuron fold 0 and replays it from the buffer for the remaining NF-1 neuron folds.
module mvau_inp_buf_ctrl #(
  parameter  int MatrixW  = 20,
  parameter  int MatrixH  = 20,
  parameter  int SIMD     = 2,
  parameter  int PE       = 2,
  localparam int SF       = MatrixW / SIMD,
  localparam int NF       = MatrixH / PE,
  localparam int BUF_ADDR = (SF > 1) ? $clog2(SF) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_v,
  output logic                in_rdy,
  input  logic                out_rdy,
  output logic                out_v,
  output logic                wr_en,
  output logic                rd_en,
  output logic [BUF_ADDR-1:0] addr,
  output logic                sf_last,
  output logic                nf_last,
  output logic [1:0]          dbg_state
);

  localparam int NF_W = (NF > 1) ? $clog2(NF) : 1;
  localparam logic [BUF_ADDR-1:0] SF_MAX = BUF_ADDR'(SF - 1);
  localparam logic [NF_W-1:0]     NF_MAX = NF_W'(NF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t              state;
  logic [BUF_ADDR-1:0] sf_cnt;
  logic [NF_W-1:0]     nf_cnt;
  logic                beat;

  // Handshake: a word moves on a cycle where its valid and the receiver's ready are both
  // high. In WRITE the input word is passed straight through, so in_rdy mirrors out_rdy
  // and out_v mirrors in_v; in READ the buffer is the source and out_v is held high.
  always_comb begin
    in_rdy  = 1'b0;
    out_v   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    beat    = 1'b0;
    case (state)
      WRITE: begin
        in_rdy = out_rdy;
        out_v  = in_v;
        wr_en  = in_v & out_rdy;
        beat   = in_v & out_rdy;
      end
      READ: begin
        rd_en = 1'b1;
        out_v = 1'b1;
        beat  = out_rdy;
      end
      default: ;
    endcase
    addr    = sf_cnt;
    sf_last = out_v & (sf_cnt == SF_MAX);
    nf_last = out_v & (nf_cnt == NF_MAX);
  end

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sf_cnt <= '0;
      nf_cnt <= '0;
    end else begin
      case (state)
        IDLE: state <= WRITE;
        WRITE, READ: begin
          if (beat) begin
            if (sf_cnt == SF_MAX) begin
              sf_cnt <= '0;
              nf_cnt <= (nf_cnt == NF_MAX) ? '0 : nf_cnt + 1'b1;
              // Last synapse fold closes a neuron fold; the final one returns to WRITE.
              if (state == WRITE) state <= (NF > 1) ? READ : WRITE;
              else                state <= (nf_cnt == NF_MAX) ? WRITE : READ;
            end else begin
              sf_cnt <= sf_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
